// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset PC and fetch state encoding for the instruction path
package cpu_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INSTR_W = 64;
  localparam logic [31:0] DEF_RESET_PC = '0;
  localparam int DEF_PC_STEP = DEF_INSTR_W / 8;
  typedef enum logic {FETCH_REQ, FETCH_HOLD} fetch_state_t;
  function automatic int pc_step(input int instr_w);
    return instr_w / 8;
  endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction memory read bus, fetch unit is master
interface instruction_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 64
);
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_ready;
  logic [INSTR_W-1:0] mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
  modport slave (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/pc_counter.sv
// pc_counter: loadable program counter stepping by one instruction word
module pc_counter #(
  parameter int ADDR_W = 32,
  parameter int STEP = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic inc,
  input logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= load_pc;
    else if (inc) pc <= pc + ADDR_W'(STEP);
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation, memory read issue and valid/stall output slot
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input logic clk,
  input logic rst,
  instruction_fetch_if.master mem,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic instr_valid,
  input logic stall,
  input logic redirect,
  input logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0] fetch_count
);
  localparam int STEP = pc_step(INSTR_W);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(STEP - 1);
  fetch_state_t state, state_nx;
  logic consume, accept;
  assign consume = instr_valid & ~stall;
  assign accept = mem.mem_req & mem.mem_ready;
  always_ff @(posedge clk)
    state <= rst ? FETCH_REQ : state_nx;
  always_comb
    state_nx = redirect ? FETCH_REQ :
               state == FETCH_REQ ? ((instr_valid & stall) ? FETCH_HOLD : FETCH_REQ) :
               (stall ? FETCH_HOLD : FETCH_REQ);
  // a redirect withdraws the request so no discarded read completes
  always_comb begin
    mem.mem_req = ~rst & ~redirect & (state == FETCH_REQ) & (~instr_valid | ~stall);
    mem.mem_addr = pc;
  end
  always_ff @(posedge clk)
    if (rst) begin
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (accept) begin
      instr <= mem.mem_rdata;
      instr_pc <= pc;
      instr_valid <= 1'b1;
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  always_ff @(posedge clk)
    if (rst) fetch_count <= '0;
    else if (consume) fetch_count <= fetch_count + 32'd1;
  pc_counter #(.ADDR_W(ADDR_W), .STEP(STEP), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .load(redirect),
    .inc(accept),
    .load_pc(redirect_pc & ALIGN),
    .pc(pc)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized run against a transaction-level model
module tb_instruction_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, ready = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [63:0] instr;
  logic [31:0] instr_pc, pc, fetch_count;
  logic instr_valid;
  logic [31:0] salt = '0;
  int tests = 0, fails = 0;
  instruction_fetch_if #(.ADDR_W(32), .INSTR_W(64)) bus();
  instruction_fetch dut (
    .clk(clk), .rst(rst), .mem(bus), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .fetch_count(fetch_count)
  );
  function automatic logic [63:0] mw(input logic [31:0] a);
    return {a * salt, 32'h11 * ((a >> 3) + 32'd1)};
  endfunction
  assign bus.mem_ready = ready;
  always_comb bus.mem_rdata = mw(bus.mem_addr);

  logic rst8 = 1'b1, ready8 = 1'b0, stall8 = 1'b0, redirect8 = 1'b0;
  logic [7:0] redirect_pc8 = '0, instr_pc8, pc8;
  logic [63:0] instr8;
  logic instr_valid8;
  logic [31:0] fetch_count8;
  instruction_fetch_if #(.ADDR_W(8), .INSTR_W(64)) bus8();
  instruction_fetch #(.ADDR_W(8), .INSTR_W(64), .RESET_PC(8'hF8)) dut8 (
    .clk(clk), .rst(rst8), .mem(bus8), .instr(instr8), .instr_pc(instr_pc8),
    .instr_valid(instr_valid8), .stall(stall8), .redirect(redirect8),
    .redirect_pc(redirect_pc8), .pc(pc8), .fetch_count(fetch_count8)
  );
  assign bus8.mem_ready = ready8;
  assign bus8.mem_rdata = {56'h0, bus8.mem_addr};

  logic m_valid = 0, m_hold = 0;
  logic [63:0] m_instr = '0;
  logic [31:0] m_ipc = '0, m_pc = '0, m_cnt = '0;

  task automatic step();
    logic req, take, cons;
    req = !rst && !redirect && !m_hold && (!m_valid || !stall);
    take = req && ready;
    cons = m_valid && !stall;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_hold = 0; m_instr = '0; m_ipc = '0; m_pc = '0; m_cnt = '0;
    end else begin
      m_cnt = m_cnt + 32'(cons);
      m_hold = !redirect && m_valid && stall;
      if (redirect) begin
        m_pc = redirect_pc & ~32'h7;
        m_valid = 0;
      end else if (take) begin
        m_instr = mw(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd8;
      end else if (cons) m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; ready = 1; stall = 0; redirect = 0;
    #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %0b exp 0", bus.mem_req); end
    step(); step();
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b exp 0", instr_valid); end
    tests++; if (instr !== 64'h0) begin fails++; $display("FAIL rst_instr got %0h exp 0", instr); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_ipc got %0h exp 0", instr_pc); end
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %0h exp 0", pc); end
    tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL rst_count got %0h exp 0", fetch_count); end
  endtask

  task automatic test_free_run();
    rst = 0; ready = 1; stall = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL fr_req got %0b exp 1", bus.mem_req); end
      tests++; if (bus.mem_addr !== 32'(i * 8)) begin fails++; $display("FAIL fr_addr got %0h exp %0h", bus.mem_addr, i * 8); end
      step();
      tests++; if (instr !== 64'(64'h11 * (i + 1))) begin fails++; $display("FAIL fr_instr got %0h exp %0h", instr, 64'h11 * (i + 1)); end
      tests++; if (instr_pc !== 32'(i * 8)) begin fails++; $display("FAIL fr_ipc got %0h exp %0h", instr_pc, i * 8); end
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL fr_valid got %0b exp 1", instr_valid); end
    end
    ready = 0;
    #1; step();
    tests++; if (fetch_count !== 32'd3) begin fails++; $display("FAIL fr_count got %0d exp 3", fetch_count); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL fr_drain got %0b exp 0", instr_valid); end
  endtask

  task automatic test_mem_wait();
    rst = 1; step(); rst = 0; ready = 1; stall = 0; step();
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL mw_req got %0b exp 1", bus.mem_req); end
      tests++; if (bus.mem_addr !== 32'h8) begin fails++; $display("FAIL mw_addr got %0h exp 8", bus.mem_addr); end
      step();
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL mw_valid got %0b exp 0", instr_valid); end
    end
    ready = 1;
    #1; step();
    tests++; if (instr !== 64'h22) begin fails++; $display("FAIL mw_instr got %0h exp 22", instr); end
    tests++; if (instr_pc !== 32'h8) begin fails++; $display("FAIL mw_ipc got %0h exp 8", instr_pc); end
  endtask

  task automatic test_stall();
    rst = 1; step(); rst = 0; ready = 1; stall = 0; step();
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL st_req got %0b exp 0", bus.mem_req); end
      step();
      tests++; if (instr !== 64'h11 || instr_valid !== 1'b1) begin fails++; $display("FAIL st_hold got %0h/%0b exp 11/1", instr, instr_valid); end
      tests++; if (fetch_count !== 32'd0) begin fails++; $display("FAIL st_count got %0d exp 0", fetch_count); end
    end
    stall = 0;
    #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL st_release_req got %0b exp 0", bus.mem_req); end
    step();
    tests++; if (fetch_count !== 32'd1) begin fails++; $display("FAIL st_release_count got %0d exp 1", fetch_count); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL st_release_valid got %0b exp 0", instr_valid); end
    #1;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin fails++; $display("FAIL st_next got %0b@%0h exp 1@8", bus.mem_req, bus.mem_addr); end
    step();
    tests++; if (instr !== 64'h22 || instr_pc !== 32'h8) begin fails++; $display("FAIL st_instr got %0h@%0h exp 22@8", instr, instr_pc); end
    ready = 0;
    #1; step();
    tests++; if (fetch_count !== 32'd2) begin fails++; $display("FAIL st_count2 got %0d exp 2", fetch_count); end
  endtask

  task automatic test_redirect();
    rst = 1; step(); rst = 0; ready = 1; stall = 0; step(); step();
    redirect = 1; redirect_pc = 32'h100;
    #1; step(); redirect = 0;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rd_valid got %0b exp 0", instr_valid); end
    tests++; if (pc !== 32'h100) begin fails++; $display("FAIL rd_pc got %0h exp 100", pc); end
    tests++; if (fetch_count !== 32'd2) begin fails++; $display("FAIL rd_count got %0d exp 2", fetch_count); end
    #1;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin fails++; $display("FAIL rd_addr got %0b@%0h exp 1@100", bus.mem_req, bus.mem_addr); end
    step();
    tests++; if (instr_pc !== 32'h100 || instr !== mw(32'h100)) begin fails++; $display("FAIL rd_instr got %0h@%0h exp %0h@100", instr, instr_pc, mw(32'h100)); end
    redirect = 1; redirect_pc = 32'h205;
    #1; step(); redirect = 0;
    tests++; if (pc !== 32'h200) begin fails++; $display("FAIL rd_align got %0h exp 200", pc); end
    #1; step();
    tests++; if (instr_pc !== 32'h200) begin fails++; $display("FAIL rd_align_ipc got %0h exp 200", instr_pc); end
  endtask

  task automatic test_reset_mid();
    stall = 1; ready = 1;
    #1; step(); step();
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL rm_pre got %0b exp 1", instr_valid); end
    rst = 1;
    #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rm_req got %0b exp 0", bus.mem_req); end
    step(); rst = 0; stall = 0;
    tests++; if (instr_valid !== 1'b0 || instr !== 64'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL rm_slot got %0b/%0h/%0h exp 0/0/0", instr_valid, instr, instr_pc); end
    tests++; if (pc !== 32'h0 || fetch_count !== 32'h0) begin fails++; $display("FAIL rm_pc_count got %0h/%0h exp 0/0", pc, fetch_count); end
    #1;
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin fails++; $display("FAIL rm_restart got %0b@%0h exp 1@0", bus.mem_req, bus.mem_addr); end
    step();
    tests++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin fails++; $display("FAIL rm_first got %0h/%0b exp 0/1", instr_pc, instr_valid); end
  endtask

  task automatic test_count_wrap();
    ready = 1; stall = 0;
    force dut.fetch_count = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_count;
    m_cnt = 32'hFFFF_FFFE;
    step();
    tests++; if (fetch_count !== 32'hFFFF_FFFF) begin fails++; $display("FAIL cw_max got %0h exp ffffffff", fetch_count); end
    step();
    tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL cw_wrap got %0h exp 0", fetch_count); end
  endtask

  task automatic test_pc_wrap();
    rst8 = 1; ready8 = 1;
    step(); rst8 = 0;
    #1;
    tests++; if (bus8.mem_req !== 1'b1 || bus8.mem_addr !== 8'hF8) begin fails++; $display("FAIL pw_first got %0b@%0h exp 1@f8", bus8.mem_req, bus8.mem_addr); end
    step();
    tests++; if (instr_pc8 !== 8'hF8 || instr8 !== 64'hF8) begin fails++; $display("FAIL pw_instr got %0h@%0h exp f8@f8", instr8, instr_pc8); end
    tests++; if (pc8 !== 8'h00) begin fails++; $display("FAIL pw_pc got %0h exp 0", pc8); end
    tests++; if (bus8.mem_addr !== 8'h00) begin fails++; $display("FAIL pw_addr got %0h exp 0", bus8.mem_addr); end
    step();
    tests++; if (instr_pc8 !== 8'h00) begin fails++; $display("FAIL pw_second got %0h exp 0", instr_pc8); end
  endtask

  task automatic test_random();
    logic er;
    salt = $urandom;
    rst = 1; redirect = 0; step(); rst = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      ready = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 2) == 0);
      #1;
      er = !rst && !redirect && !m_hold && (!m_valid || !stall);
      tests++; if (bus.mem_req !== er) begin fails++; $display("FAIL rnd_req cyc %0d got %0b exp %0b", i, bus.mem_req, er); end
      if (er) begin
        tests++; if (bus.mem_addr !== m_pc) begin fails++; $display("FAIL rnd_addr cyc %0d got %0h exp %0h", i, bus.mem_addr, m_pc); end
      end
      step();
      tests++; if (instr_valid !== m_valid) begin fails++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", i, instr_valid, m_valid); end
      if (m_valid) begin
        tests++; if (instr !== m_instr || instr_pc !== m_ipc) begin fails++; $display("FAIL rnd_instr cyc %0d got %0h@%0h exp %0h@%0h", i, instr, instr_pc, m_instr, m_ipc); end
      end
      tests++; if (pc !== m_pc) begin fails++; $display("FAIL rnd_pc cyc %0d got %0h exp %0h", i, pc, m_pc); end
      tests++; if (fetch_count !== m_cnt) begin fails++; $display("FAIL rnd_count cyc %0d got %0h exp %0h", i, fetch_count, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_mem_wait();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_count_wrap();
    test_pc_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Producer side of the 64-bit instruction path. Generates the program counter, issues word reads to instruction memory and captures the returned 64-bit instruction word.
- Presents the instruction with a valid/stall handshake to the consumer, which is the instruction register's input stage.
- Supports branch redirect and counts delivered instructions.

Parameters:
- ADDR_W, 32, width of the PC and memory address.
- INSTR_W, 64, instruction word width. The PC step is INSTR_W/8 bytes.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all logic is on the posedge.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  read request, held high until accepted.
- mem_addr  output  ADDR_W  read address; stable while mem_req is high.
- mem_ready  input  1  memory accepts the request and returns mem_rdata in the same cycle.
- mem_rdata  input  INSTR_W  instruction data; valid only when mem_req and mem_ready are both high.
- instr  output  INSTR_W  fetched instruction.
- instr_pc  output  ADDR_W  address of instr.
- instr_valid  output  1  instr is valid.
- stall  input  1  consumer cannot take instr this cycle.
- redirect  input  1  discard the current fetch and output, then restart at redirect_pc.
- redirect_pc  input  ADDR_W  new fetch address; must be INSTR_W/8 aligned.
- pc  output  ADDR_W  next address to fetch.
- fetch_count  output  32  number of instructions consumed since reset.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=REQ.
  - instr=0, instr_pc=0, instr_valid=0, fetch_count=0.
  - Reset overrides redirect and any in-flight request. mem_req is 0 in the cycle rst is high.
- Consume event: instr_valid & ~stall. fetch_count increments by 1 on each consume and wraps modulo 2^32.
- States:
  - REQ:
    - mem_req=1, mem_addr=pc. The request is allowed only while the output slot is free or being consumed this cycle, i.e. ~instr_valid | ~stall.
    - On mem_ready: instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+INSTR_W/8 (wraps modulo 2^ADDR_W). Stay in REQ.
    - If the slot is full and stall=1: go to HOLD with mem_req=0.
  - HOLD:
    - mem_req=0. instr, instr_pc and instr_valid are held.
    - When stall drops: that cycle is a consume, and the state returns to REQ at the next edge.
- Latency: a request accepted in cycle N gives instr_valid=1 in cycle N+1. Back-to-back throughput is one instruction per cycle while mem_ready=1 and stall=0.
- A consume without a simultaneous capture clears instr_valid at the next edge.
- mem_addr must not change while mem_req=1 and mem_ready=0, except on redirect.
- Redirect (highest priority below rst):
  - At the next edge: pc<=redirect_pc, instr_valid<=0, state<=REQ.
  - Data accepted in the same cycle as redirect is discarded; pc does not step.
  - Consume still counts if instr_valid & ~stall in the redirect cycle.
  - mem_req may drop for the redirect cycle. The memory must tolerate a withdrawn request.
- Stall during the mem_ready cycle with the slot full is not possible, because no request is issued. Stall with the slot empty does not block the request.
- Misaligned redirect_pc: the low bits are forced to 0.

Decomposition:
- Shared package `cpu_pkg`:
  - INSTR_W, ADDR_W and RESET_PC defaults.
  - PC step constant.
  - Fetch state enum {FETCH_REQ, FETCH_HOLD}.
- Sub-module `pc_counter`: loadable PC register with increment by step, synchronous load, and synchronous reset to RESET_PC.
- FSM, output slot and counter stay in the top level.

Test Plan:
- Reset then free run: rst for 2 cycles, mem_ready=1, rdata=0x11,0x22,0x33, stall=0 -> mem_addr 0,8,16. instr 0x11@pc0, 0x22@8, 0x33@16 on consecutive cycles. fetch_count=3.
- Memory wait: mem_ready low for 3 cycles at addr 8 -> mem_addr held at 8 with mem_req=1, instr_valid=0 during the wait. Then instr=rdata, instr_pc=8.
- Stall backpressure: stall=1 for 4 cycles after the first instr -> instr held at 0x11, mem_req=0, fetch_count frozen. Release -> next fetch at addr 8, count increments once per consume.
- Redirect: redirect=1, redirect_pc=0x100 while mem_ready=1 at addr 16 -> rdata dropped, instr_valid=0 next cycle, next mem_addr=0x100, then instr_pc=0x100.
- Reset mid-operation: rst during HOLD with instr_valid=1 -> all outputs go to reset values next cycle, and fetching restarts at RESET_PC.
- Wrap: ADDR_W=8, RESET_PC=0xF8 -> second fetch at addr 0x00. fetch_count preset near 2^32-1 via long run or force -> wraps to 0.
